// File: rtl/stage_if_id.sv
// IF/ID pipeline register with pre-decode: latches fetch output, kills on
// MEM-resolved redirects, holds on load-use hazards and counts stall cycles.
module stage_if_id (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_PC4,
  input  logic [31:0] IF_Inst,
  input  logic        IF_Valid,
  input  logic        MEM_PCSrc,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic [31:0] ID_Inst,
  output logic        ID_Valid,
  output logic [4:0]  ID_Rs,
  output logic [4:0]  ID_Rt,
  output logic [4:0]  ID_Rd,
  output logic [31:0] ID_Imm32,
  output logic        ID_Stall,
  output logic [15:0] ID_StallCnt
);

  logic [5:0] opcode;
  logic       uses_rt;
  logic       zero_ext;
  logic       rs_hit;
  logic       rt_hit;

  assign opcode = ID_Inst[31:26];
  assign ID_Rs  = ID_Inst[25:21];
  assign ID_Rt  = ID_Inst[20:16];
  assign ID_Rd  = ID_Inst[15:11];

  always_comb begin
    uses_rt  = 1'b0;
    zero_ext = 1'b0;
    case (opcode)
      6'b000000, 6'b000100, 6'b000101, 6'b101011: uses_rt = 1'b1;
      default: uses_rt = 1'b0;
    endcase
    case (opcode)
      6'b001100, 6'b001101, 6'b001110: zero_ext = 1'b1;
      default: zero_ext = 1'b0;
    endcase
  end

  assign ID_Imm32 = zero_ext ? {16'h0000, ID_Inst[15:0]}
                             : {{16{ID_Inst[15]}}, ID_Inst[15:0]};

  // Hazard only looks at registered ID state and EX, never at IF inputs.
  assign rs_hit   = (EX_Rt == ID_Rs);
  assign rt_hit   = uses_rt && (EX_Rt == ID_Rt);
  assign ID_Stall = ID_Valid && EX_MemRead && (EX_Rt != 5'd0) && (rs_hit || rt_hit);

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      ID_PC    <= 32'h0;
      ID_PC4   <= 32'h0;
      ID_Inst  <= 32'h0;
      ID_Valid <= 1'b0;
    end else if (MEM_PCSrc) begin
      ID_Inst  <= 32'h0;
      ID_Valid <= 1'b0;
    end else if (!ID_Stall) begin
      ID_PC    <= IF_PC;
      ID_PC4   <= IF_PC4;
      ID_Inst  <= IF_Inst;
      ID_Valid <= IF_Valid;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      ID_StallCnt <= 16'h0000;
    end else if (ID_Stall && !MEM_PCSrc && (ID_StallCnt != 16'hFFFF)) begin
      ID_StallCnt <= ID_StallCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_stage_if_id.sv
// Self-checking bench for stage_if_id: vector table through a scoreboard
// queue, then saturation and asynchronous-reset sequences.
module tb_stage_if_id;

  logic        Clk = 1'b0;
  logic        Clrn;
  logic [31:0] IF_PC, IF_PC4, IF_Inst;
  logic        IF_Valid, MEM_PCSrc, EX_MemRead;
  logic [4:0]  EX_Rt;
  logic [31:0] ID_PC, ID_PC4, ID_Inst, ID_Imm32;
  logic        ID_Valid, ID_Stall;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [15:0] ID_StallCnt;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  stage_if_id dut (
    .Clk(Clk), .Clrn(Clrn),
    .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst), .IF_Valid(IF_Valid),
    .MEM_PCSrc(MEM_PCSrc), .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
    .ID_PC(ID_PC), .ID_PC4(ID_PC4), .ID_Inst(ID_Inst), .ID_Valid(ID_Valid),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Imm32(ID_Imm32),
    .ID_Stall(ID_Stall), .ID_StallCnt(ID_StallCnt)
  );

  // Inputs applied before an edge; x_stall is checked before that edge,
  // the remaining expectations just after it.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        vld;
    logic        pcsrc;
    logic        mrd;
    logic [4:0]  ert;
    logic        x_stall;
    logic [31:0] x_pc;
    logic [31:0] x_inst;
    logic        x_vld;
    logic [15:0] x_cnt;
    logic [31:0] x_imm;
    logic [4:0]  x_rt;
  } vec_t;

  localparam int NV = 16;
  vec_t vec[NV];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IF_PC      = v.pc;
    IF_PC4     = v.pc4;
    IF_Inst    = v.inst;
    IF_Valid   = v.vld;
    MEM_PCSrc  = v.pcsrc;
    EX_MemRead = v.mrd;
    EX_Rt      = v.ert;
  endtask

  initial begin
    vec_t e;
    //          pc     pc4    inst          v  fl mr ert  stall x_pc   x_inst       x_v x_cnt  x_imm         x_rt
    vec[0]  = '{32'h40, 32'h44, 32'h8C220008, 1, 0, 0, 0,  0, 32'h40, 32'h8C220008, 1, 16'd0, 32'h00000008, 5'd2};
    vec[1]  = '{32'h44, 32'h48, 32'h00430820, 1, 0, 0, 0,  0, 32'h44, 32'h00430820, 1, 16'd0, 32'h00000820, 5'd3};
    vec[2]  = '{32'h48, 32'h4C, 32'h3C05FFFF, 1, 0, 1, 2,  1, 32'h44, 32'h00430820, 1, 16'd1, 32'h00000820, 5'd3};
    vec[3]  = '{32'h48, 32'h4C, 32'h3C05FFFF, 1, 0, 0, 0,  0, 32'h48, 32'h3C05FFFF, 1, 16'd1, 32'hFFFFFFFF, 5'd5};
    vec[4]  = '{32'h4C, 32'h50, 32'h10A60003, 1, 0, 1, 5,  0, 32'h4C, 32'h10A60003, 1, 16'd1, 32'h00000003, 5'd6};
    vec[5]  = '{32'h50, 32'h54, 32'h3421F000, 1, 0, 1, 6,  1, 32'h4C, 32'h10A60003, 1, 16'd2, 32'h00000003, 5'd6};
    vec[6]  = '{32'h50, 32'h54, 32'h3421F000, 1, 1, 1, 6,  1, 32'h4C, 32'h00000000, 0, 16'd2, 32'h00000000, 5'd0};
    vec[7]  = '{32'h50, 32'h54, 32'h3421F000, 1, 0, 1, 6,  0, 32'h50, 32'h3421F000, 1, 16'd2, 32'h0000F000, 5'd1};
    vec[8]  = '{32'h54, 32'h58, 32'h2021F000, 1, 0, 1, 0,  0, 32'h54, 32'h2021F000, 1, 16'd2, 32'hFFFFF000, 5'd1};
    vec[9]  = '{32'h58, 32'h5C, 32'h00000000, 1, 0, 1, 1,  1, 32'h54, 32'h2021F000, 1, 16'd3, 32'hFFFFF000, 5'd1};
    vec[10] = '{32'h58, 32'h5C, 32'h00000000, 1, 0, 0, 0,  0, 32'h58, 32'h00000000, 1, 16'd3, 32'h00000000, 5'd0};
    vec[11] = '{32'h5C, 32'h60, 32'h8C220008, 0, 0, 1, 0,  0, 32'h5C, 32'h8C220008, 0, 16'd3, 32'h00000008, 5'd2};
    vec[12] = '{32'h60, 32'h64, 32'h012A4020, 1, 0, 1, 1,  0, 32'h60, 32'h012A4020, 1, 16'd3, 32'h00004020, 5'd10};
    vec[13] = '{32'h64, 32'h68, 32'h3042FFFF, 1, 0, 1, 10, 1, 32'h60, 32'h012A4020, 1, 16'd4, 32'h00004020, 5'd10};
    vec[14] = '{32'h64, 32'h68, 32'h3042FFFF, 1, 0, 0, 0,  0, 32'h64, 32'h3042FFFF, 1, 16'd4, 32'h0000FFFF, 5'd2};
    vec[15] = '{32'h68, 32'h6C, 32'h38428000, 1, 0, 0, 0,  0, 32'h68, 32'h38428000, 1, 16'd4, 32'h00008000, 5'd2};

    Clrn = 1'b0;
    drive(vec[0]);
    #12;
    chk("rst_pc", ID_PC, 32'h0);
    chk("rst_pc4", ID_PC4, 32'h0);
    chk("rst_inst", ID_Inst, 32'h0);
    chk("rst_valid", {31'b0, ID_Valid}, 32'h0);
    chk("rst_stall", {31'b0, ID_Stall}, 32'h0);
    chk("rst_cnt", {16'b0, ID_StallCnt}, 32'h0);
    chk("rst_imm", ID_Imm32, 32'h0);
    chk("rst_fields", {17'b0, ID_Rs, ID_Rt, ID_Rd}, 32'h0);

    @(negedge Clk);
    Clrn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) @(negedge Clk);
      drive(vec[i]);
      sb.push_back(vec[i]);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, ID_Stall}, {31'b0, vec[i].x_stall});
      @(posedge Clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), ID_PC, e.x_pc);
      chk($sformatf("v%0d_pc4", i), ID_PC4, e.x_pc + 32'd4);
      chk($sformatf("v%0d_inst", i), ID_Inst, e.x_inst);
      chk($sformatf("v%0d_valid", i), {31'b0, ID_Valid}, {31'b0, e.x_vld});
      chk($sformatf("v%0d_cnt", i), {16'b0, ID_StallCnt}, {16'b0, e.x_cnt});
      chk($sformatf("v%0d_imm", i), ID_Imm32, e.x_imm);
      chk($sformatf("v%0d_rt", i), {27'b0, ID_Rt}, {27'b0, e.x_rt});
    end
    chk("scoreboard_empty", sb.size(), 32'd0);

    // Sustained hazard on rs=2 of the held xori; counter starts at 4.
    @(negedge Clk);
    IF_PC = 32'h6C; IF_PC4 = 32'h70; IF_Inst = 32'h00000000; IF_Valid = 1'b1;
    EX_MemRead = 1'b1; EX_Rt = 5'd2; MEM_PCSrc = 1'b0;
    for (int k = 1; k <= 65540; k++) begin
      @(posedge Clk);
      if (k == 65531) begin
        #1;
        chk("sat_reach", {16'b0, ID_StallCnt}, 32'h0000FFFF);
      end
    end
    #1;
    chk("sat_hold", {16'b0, ID_StallCnt}, 32'h0000FFFF);
    chk("sat_stall", {31'b0, ID_Stall}, 32'h1);
    chk("sat_pc_held", ID_PC, 32'h68);

    @(negedge Clk);
    Clrn = 1'b0;
    #1;
    chk("arst_cnt", {16'b0, ID_StallCnt}, 32'h0);
    chk("arst_stall", {31'b0, ID_Stall}, 32'h0);
    chk("arst_valid", {31'b0, ID_Valid}, 32'h0);
    chk("arst_pc", ID_PC, 32'h0);

    IF_PC = 32'h40; IF_PC4 = 32'h44; IF_Inst = 32'h8C220008; IF_Valid = 1'b1;
    EX_MemRead = 1'b0; EX_Rt = 5'd0;
    @(negedge Clk);
    Clrn = 1'b1;
    @(posedge Clk);
    #1;
    chk("rel_pc", ID_PC, 32'h40);
    chk("rel_inst", ID_Inst, 32'h8C220008);
    chk("rel_cnt", {16'b0, ID_StallCnt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
